serial_subtractor: RTL and testbench
====================================

# serial_subtractor

- Bit-serial unsigned subtractor: computes D = A − B one bit per clock, LSB first, through a single full-subtractor cell.
- Result plus borrow-out in a WIDTH+1-bit word, with D[WIDTH] = borrow; the inverse operation of the ripple-carry adder, with the same result-word layout (top bit = carry/borrow).
- Sits beside the adder in the arithmetic datapath; trades latency for area.
- Start/busy/done handshake.

## Interface
- WIDTH, default 4: operand width in bits; legal range 2–16.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend, latched on the accepted start.
- B  input  WIDTH  subtrahend, latched on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; D is valid from this cycle on.
- D  output  WIDTH+1  result: D[WIDTH-1:0] = (A − B) mod 2^WIDTH, D[WIDTH] = borrow-out (1 when A < B unsigned).
- ovf  output  1  signed overflow flag; exists only under SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1.
  - RUN→DONE when the bit counter reaches WIDTH−1.
  - DONE→IDLE unconditionally.
- On the accepted start:
  - A and B are loaded into shift registers.
  - Borrow register cleared to 0; bit counter cleared to 0.
- Each RUN cycle:
  - The full-subtractor takes the LSB of each shift register plus the borrow register.
  - The difference bit is shifted into the MSB of the result shift register.
  - The borrow register takes the cell's borrow-out.
  - A and B shift right; the counter increments.
- On the final RUN edge, the output register D is loaded with {final borrow, complete difference}. D changes only at this edge.
- Between completions, D holds the previous result, including throughout RUN.
- start is ignored in RUN and DONE; it is not queued.
- A and B inputs are don't-care after the accepted start.
- Full-subtractor equations, per bit:
  - diff = a ^ b ^ bin
  - bout = (~a & b) | (~(a ^ b) & bin)
- Reset values: state IDLE, busy 0, done 0, D 0, ovf 0; internal shift registers, borrow and counter cleared to 0.
- rst asserted in any state, including mid-RUN: the operation is aborted, all of the above take their reset values at that edge, and no done is issued.
- rst has priority over start in the same cycle.

## Timing
- Accepted start at edge E0: busy is high from E0 to EWIDTH.
- done is high for exactly one cycle, from EWIDTH to EWIDTH+1. D is updated at EWIDTH.
- Latency: WIDTH cycles from the start edge to done.
- Earliest next accepted start: edge EWIDTH+2, since the block must be back in IDLE.
- Throughput: one result per WIDTH+2 cycles with start held continuously high.
- No combinational path from any input to any output; every output is registered.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - ovf port present.
  - ovf is loaded at the same edge as D, with (A_msb ≠ B_msb) & (D[WIDTH-1] ≠ A_msb), using the latched operand MSBs.
  - ovf holds with D and resets to 0.
- SERIAL_SUB_OVF_EN undefined: no ovf port and no associated registers. All other behaviour is identical.

## Structure
- Shared package serial_sub_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Constants MIN_WIDTH=2 and MAX_WIDTH=16, used for a parameter range check.
- One sub-module, full_sub: purely combinational one-bit full subtractor with ports a, b, bin, diff, bout.
- Top module contents: FSM, counter, shift registers, output registers, one full_sub instance.

## Test plan
- Reset, then start with A=9, B=3 (WIDTH=4) → busy for 4 cycles, done 4 cycles after start, D=5'b0_0110.
- A=3, B=9 → D=5'b1_1010 (borrow 1). A=0, B=1 → D=5'b1_1111. A=5, B=5 → D=5'b0_0000.
- start held high, with A and B toggled every cycle during RUN:
  - Exactly one result, computed from the values latched at the accepted start.
  - The next accepted start comes 6 cycles after the first.
  - D is unchanged during the second RUN until its done.
- rst asserted in the 2nd RUN cycle of A=12, B=4:
  - At that edge: busy=0, D=0.
  - No done pulse follows.
  - The next start with A=12, B=4 yields D=5'b0_1000.
- With SERIAL_SUB_OVF_EN:
  - A=4'b0111, B=4'b1000 → D=5'b1_1111, ovf=1.
  - A=4'b0010, B=4'b0001 → D=5'b0_0001, ovf=0.
- WIDTH=8, A=8'h00, B=8'hFF → done after 8 cycles, D=9'h101.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type,
// legal operand-width bounds and the signed-overflow helper.
package serial_sub_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of a two's-complement subtraction: the operands have
    // opposite signs and the result sign differs from the minuend sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   D;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, A, B, input busy, done, D, ovf);
    modport slave  (input start, A, B, output busy, done, D, ovf);
`else
    modport master (output start, A, B, input busy, done, D);
    modport slave  (input start, A, B, output busy, done, D);
`endif
endinterface

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor: diff = a - b - bin, bout set when a borrow
// must be taken from the next more significant bit.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, one bit per clock, LSB first.
// D[WIDTH] is the final borrow; D only changes at the last RUN edge.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered signed
// overflow flag ovf, loaded together with D.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
            $error("serial_subtractor: WIDTH out of range");
        end
    endgenerate

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH:0]     r_d;

    logic               w_diff;
    logic               w_bout;
    logic [WIDTH-1:0]   w_res_shift;

    // The single arithmetic cell, fed by the operand LSBs and the borrow.
    full_sub u_full_sub (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bout)
    );

    // Result bits collected so far with the current difference bit on top.
    assign w_res_shift = {w_diff, r_res};

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = DONE;
                    w_last      = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered busy/done derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == RUN);
            r_done <= (w_state_nxt == DONE);
        end
    end

    // Operand shift registers, borrow, partial result and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_res    <= w_res_shift[WIDTH-1:1];
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Output word: loaded only on the final RUN edge, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= '0;
        end else if (w_last) begin
            r_d <= {w_bout, w_res_shift};
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.D    = r_d;

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand sign bits kept aside since the shift registers lose them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_load) begin
            r_a_msb <= bus.A[WIDTH-1];
            r_b_msb <= bus.B[WIDTH-1];
        end
    end

    // Signed overflow, updated in step with D (last diff bit is the sign).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= sub_ovf(r_a_msb, r_b_msb, w_diff);
        end
    end

    assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_serial_subtractor;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [W+1:0] sb_q[$];      // {ovf, D}
    logic [W+1:0] mon_exp;
    logic [W:0]   last_d;
    logic [W:0]   first_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned difference with borrow, computed arithmetically.
    function automatic logic [W:0] model_d(input int a, input int b);
        int lower;
        int borrow;
        borrow = (a < b) ? 1 : 0;
        lower  = (a < b) ? (a + (1 << W) - b) : (a - b);
        return (W+1)'((borrow << W) + lower);
    endfunction

    // Reference: signed result falls outside the W-bit two's-complement range.
    function automatic logic model_ovf(input int a, input int b);
        int sa;
        int sb;
        int sd;
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        sd = sa - sb;
        return (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
    endfunction

    function automatic logic [W+1:0] expect_of(input int a, input int b);
        return {model_ovf(a, b), model_d(a, b)};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result at %0t", $time);
            end else begin
                mon_exp = sb_q.pop_front();
                check("result_D", 32'(bus.D), 32'(mon_exp[W:0]));
`ifdef SERIAL_SUB_OVF_EN
                check("result_ovf", 32'(bus.ovf), 32'(mon_exp[W+1]));
`endif
            end
        end
    end

    // Count cycles from the start edge to done; busy and held D checked meanwhile.
    task automatic wait_done(input logic [W:0] hold_val);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check("busy_in_run", 32'(bus.busy), 32'd1);
            check("D_hold_in_run", 32'(bus.D), 32'(hold_val));
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done after %0d cycles", W);
        end else begin
            check("latency", 32'(n), 32'(W));
            check("busy_at_done", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic do_op(input int a, input int b);
        logic [W+1:0] e;
        e = expect_of(a, b);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.A     = W'(a);
        bus.B     = W'(b);
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        wait_done(last_d);
        last_d = e[W:0];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1);
    end

    initial begin
        logic [W+1:0] e2;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        last_d    = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_D", 32'(bus.D), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif

        // Directed operands.
        do_op(9, 3);
        do_op(3, 9);
        do_op(0, 1);
        do_op(5, 5);
        do_op(15, 0);
        do_op(0, 15);

        // start held high with operands toggling every cycle.
        e2 = expect_of(6, 11);
        first_d = e2[W:0];
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.A     = W'(6);
        bus.B     = W'(11);
        sb_q.push_back(e2);
        for (int j = 1; j <= W + 2; j++) begin
            @(posedge clk); #1;
            if (j == W + 2) begin
                check("held_idle_before_restart", 32'(bus.busy), 32'd0);
            end
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            if (j == W + 2) begin
                e2 = expect_of(int'(bus.A), int'(bus.B));
                sb_q.push_back(e2);
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("held_restart_busy", 32'(bus.busy), 32'd1);
        wait_done(first_d);
        last_d = e2[W:0];

        // Reset in the second RUN cycle aborts the operation.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.A     = W'(12);
        bus.B     = W'(4);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_D", 32'(bus.D), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        rst    = 1'b0;
        last_d = '0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        do_op(12, 4);

`ifdef SERIAL_SUB_OVF_EN
        do_op(7, 8);
        do_op(2, 1);
        do_op(8, 1);
`endif

        // Randomized operands against the reference model.
        for (int r = 0; r < 30; r++) begin
            do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
